// File: rtl/mux_sel_scheduler.sv
// rtl/mux_sel_scheduler.sv - 2:1 mux select scheduler with switch blanking (optional stats: MUX_SEL_SCHEDULER_STATS_EN)
module mux_sel_scheduler #(
  parameter int CNT_WIDTH   = 32,
  parameter int BLANK_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mode_i,
  input  logic                   manual_sel_i,
  input  logic [CNT_WIDTH-1:0]   period0_i,
  input  logic [CNT_WIDTH-1:0]   period1_i,
  input  logic [BLANK_WIDTH-1:0] blank_len_i,
  output logic                   sel_o,
  output logic                   blank_o,
  output logic                   switch_pulse_o,
  output logic [31:0]            switch_count_o
);

  typedef enum logic [1:0] {
    DWELL = 2'd0,
    PRE   = 2'd1,
    POST  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BLANK_WIDTH-1:0] n_q, n_d;
  logic [BLANK_WIDTH-1:0] rem_q, rem_d;
  logic                   sel_q, sel_d;
  logic                   blank_q, blank_d;
  logic                   pulse_q, pulse_d;
  logic                   mode_q;

  logic [CNT_WIDTH-1:0]   period_cur;
  logic [CNT_WIDTH-1:0]   target;
  logic                   mode_chg;
  logic                   req;

  // Switch request: live period for the current input, a period of 0 behaves as 1.
  // The cycle a mode change is seen, the counter restarts and cannot trigger an auto switch.
  always_comb begin
    period_cur = sel_q ? period1_i : period0_i;
    target     = (period_cur == '0) ? '0 : period_cur - CNT_WIDTH'(1);
    mode_chg   = (mode_i != mode_q);
    req        = mode_i ? (!mode_chg && (cnt_q == target)) : (manual_sel_i != sel_q);
  end

  // Next-state and registered-output logic for the DWELL/PRE/POST sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    blank_d = blank_q;
    pulse_d = 1'b0;
    case (state_q)
      DWELL: begin
        blank_d = 1'b0;
        if (mode_chg) begin
          cnt_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (req) begin
          cnt_d = '0;
          if (blank_len_i == '0) begin
            sel_d   = ~sel_q;
            pulse_d = 1'b1;
          end else begin
            // Switch is committed from here; later input changes wait for DWELL.
            n_d     = blank_len_i;
            rem_d   = blank_len_i - BLANK_WIDTH'(1);
            blank_d = 1'b1;
            state_d = PRE;
          end
        end
      end
      PRE: begin
        blank_d = 1'b1;
        if (rem_q == '0) begin
          sel_d   = ~sel_q;
          pulse_d = 1'b1;
          // POST lasts N+1 cycles to cover the downstream mux register.
          rem_d   = n_q;
          state_d = POST;
        end else begin
          rem_d = rem_q - BLANK_WIDTH'(1);
        end
      end
      POST: begin
        if (rem_q == '0) begin
          blank_d = 1'b0;
          cnt_d   = '0;
          state_d = DWELL;
        end else begin
          blank_d = 1'b1;
          rem_d   = rem_q - BLANK_WIDTH'(1);
        end
      end
      default: begin
        blank_d = 1'b0;
        cnt_d   = '0;
        state_d = DWELL;
      end
    endcase
  end

  // State and output registers; mode is tracked through reset so release does not look like a change.
  always_ff @(posedge clk_i) begin
    mode_q <= mode_i;
    if (!rst_ni) begin
      state_q <= DWELL;
      cnt_q   <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      sel_q   <= 1'b0;
      blank_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  assign sel_o          = sel_q;
  assign blank_o        = blank_q;
  assign switch_pulse_o = pulse_q;

`ifdef MUX_SEL_SCHEDULER_STATS_EN
  logic [31:0] count_q;

  // Switch counter advances with each pulse and wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (pulse_d) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign switch_count_o = count_q;
`else
  assign switch_count_o = 32'd0;
`endif

endmodule
